// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring consumers.
package ring_pkg;

    // Lock FSM states of the sequence checker.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    // Widest ring word the generic helpers below handle.
    localparam int MAX_WIDTH = 64;

    // Index width for a ring of the given width (never less than one bit).
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Rotate the low 'width' bits of word left by one; bits above 'width' come back zero.
    function automatic logic [MAX_WIDTH-1:0] rotl1(input logic [MAX_WIDTH-1:0] word,
                                                   input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r[(i + 1) % width] = word[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot test and binary decode of a ring word.
module ring_onehot_decode #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] ring_i,
    output logic             is_onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign is_onehot_o = (ring_i != '0) && ((ring_i & (ring_i - 1'b1)) == '0);

    // Priority encode the set bit; only meaningful when is_onehot_o is high.
    always_comb begin
        // NOTE: default assignment first so no path leaves idx_o unassigned (no latch).
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side checker for rotate-left one-hot ring words: decode, lock FSM, error count.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = idx_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IDX_W-1:0]     idx_out,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    ring_state_e          state_q;
    logic [WIDTH-1:0]     ref_q;
    logic [GOOD_W-1:0]    good_cnt_q;
    logic [IDX_W-1:0]     idx_out_q;
    logic                 idx_valid_q;
    logic                 locked_q;
    logic                 onehot_err_q;
    logic                 seq_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic                 is_onehot;
    logic [IDX_W-1:0]     dec_idx;
    logic [MAX_WIDTH-1:0] expected_wide;
    logic                 match;
    logic                 onehot_err_d;
    logic                 seq_err_d;
    logic [GOOD_W-1:0]    good_cnt_d;

    ring_onehot_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .ring_i      (ring_in),
        .is_onehot_o (is_onehot),
        .idx_o       (dec_idx)
    );

    // Expected successor is the reference rotated left; compare at full helper width
    // (upper bits of both sides are zero).
    assign expected_wide = rotl1(MAX_WIDTH'(ref_q), WIDTH);
    assign match         = (expected_wide == MAX_WIDTH'(ring_in));

    // Error classification and match-run count for the sample at this edge.
    always_comb begin
        onehot_err_d = in_valid && !is_onehot;
        seq_err_d    = in_valid && is_onehot && (state_q != HUNT) && !match;
        good_cnt_d   = good_cnt_q + GOOD_W'(1);
    end

    // Lock FSM with registered decode, flag and error-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            ref_q        <= '0;
            good_cnt_q   <= '0;
            idx_out_q    <= '0;
            idx_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read above sees the
            // pre-edge value and later assignments in this block override earlier ones.
            idx_valid_q  <= 1'b0;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;

            if (in_valid) begin
                if (is_onehot) begin
                    idx_out_q   <= dec_idx;
                    idx_valid_q <= 1'b1;
                end

                unique case (state_q)
                    HUNT: begin
                        if (is_onehot) begin
                            ref_q      <= ring_in;
                            good_cnt_q <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!is_onehot) begin
                            state_q <= HUNT;
                        end else if (match) begin
                            ref_q      <= ring_in;
                            good_cnt_q <= good_cnt_d;
                            if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            ref_q      <= ring_in;
                            good_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_onehot) begin
                            locked_q <= 1'b0;
                            state_q  <= HUNT;
                        end else if (match) begin
                            ref_q <= ring_in;
                        end else begin
                            locked_q   <= 1'b0;
                            ref_q      <= ring_in;
                            good_cnt_q <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    default: begin
                        locked_q <= 1'b0;
                        state_q  <= HUNT;
                    end
                endcase
            end

            if ((onehot_err_d || seq_err_d) && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign idx_out    = idx_out_q;
    assign idx_valid  = idx_valid_q;
    assign locked     = locked_q;
    assign onehot_err = onehot_err_q;
    assign seq_err    = seq_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed bench for ring_sequence_checker (WIDTH=4, LOCK_COUNT=2; second instance with ERR_CNT_W=2).
module tb_ring_sequence_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] ring_in;
    logic [1:0] idx_out;
    logic       idx_valid, locked, onehot_err, seq_err;
    logic [7:0] err_count;

    logic       rst2;
    logic       in_valid2;
    logic [3:0] ring_in2;
    logic [1:0] idx_out2;
    logic       idx_valid2, locked2, onehot_err2, seq_err2;
    logic [1:0] err_count2;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] ring;
        logic [1:0] idx;
        logic       iv;
        logic       lk;
        logic       oe;
        logic       se;
        logic [7:0] ec;
    } step_t;

    always #5 clk = ~clk;

    ring_sequence_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ring_in    (ring_in),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    ring_sequence_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst2),
        .in_valid   (in_valid2),
        .ring_in    (ring_in2),
        .idx_out    (idx_out2),
        .idx_valid  (idx_valid2),
        .locked     (locked2),
        .onehot_err (onehot_err2),
        .seq_err    (seq_err2),
        .err_count  (err_count2)
    );

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        ring_in  = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !== 14'd0)
            $display("FAIL test_reset: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want all zero",
                     idx_out, idx_valid, locked, onehot_err, seq_err, err_count);
        else passed++;
    endtask

    task automatic test_basic_lock();
        step_t s [5];
        s = '{'{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = s[i].v; ring_in = s[i].ring;
            @(posedge clk); #1;
            total++;
            if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !==
                {s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec})
                $display("FAIL test_basic_lock step %0d: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d",
                         i, idx_out, idx_valid, locked, onehot_err, seq_err, err_count,
                         s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_onehot_err();
        step_t s [7];
        s = '{'{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0011, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
              '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
              '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = s[i].v; ring_in = s[i].ring;
            @(posedge clk); #1;
            total++;
            if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !==
                {s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec})
                $display("FAIL test_onehot_err step %0d: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d",
                         i, idx_out, idx_valid, locked, onehot_err, seq_err, err_count,
                         s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_seq_err();
        step_t s [7];
        s = '{'{1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
              '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2}};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = s[i].v; ring_in = s[i].ring;
            @(posedge clk); #1;
            total++;
            if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !==
                {s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec})
                $display("FAIL test_seq_err step %0d: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d",
                         i, idx_out, idx_valid, locked, onehot_err, seq_err, err_count,
                         s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        step_t s [13];
        s = '{'{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b1111, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
              '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid = s[i].v; ring_in = s[i].ring;
            @(posedge clk); #1;
            total++;
            if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !==
                {s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec})
                $display("FAIL test_gaps step %0d: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d",
                         i, idx_out, idx_valid, locked, onehot_err, seq_err, err_count,
                         s[i].idx, s[i].iv, s[i].lk, s[i].oe, s[i].se, s[i].ec);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_err_saturate();
        logic [1:0] exp_ec [5];
        exp_ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst2 = 1'b1; in_valid2 = 1'b0; ring_in2 = 4'b0000;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1; ring_in2 = 4'b0000;
            @(posedge clk); #1;
            total++;
            if ({onehot_err2, seq_err2, locked2, idx_valid2, err_count2} !== {4'b1000, exp_ec[i]})
                $display("FAIL test_err_saturate step %0d: got oe=%b se=%b lk=%b iv=%b ec=%0d, want oe=1 se=0 lk=0 iv=0 ec=%0d",
                         i, onehot_err2, seq_err2, locked2, idx_valid2, err_count2, exp_ec[i]);
            else passed++;
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_reset_while_locked();
        ring_in = 4'b0001; in_valid = 1'b1; @(posedge clk); #1;
        ring_in = 4'b0010;                  @(posedge clk); #1;
        ring_in = 4'b0100;                  @(posedge clk); #1;
        total++;
        if (locked !== 1'b1)
            $display("FAIL test_reset_while_locked pre-lock: got lk=%b, want lk=1", locked);
        else passed++;
        rst = 1'b1; in_valid = 1'b1; ring_in = 4'b0100;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !== 14'd0)
            $display("FAIL test_reset_while_locked reset: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want all zero",
                     idx_out, idx_valid, locked, onehot_err, seq_err, err_count);
        else passed++;
        in_valid = 1'b1; ring_in = 4'b1000;
        @(posedge clk); #1;
        total++;
        if ({idx_out, idx_valid, locked, onehot_err, seq_err, err_count} !== {2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0})
            $display("FAIL test_reset_while_locked new_ref: got idx=%0d iv=%b lk=%b oe=%b se=%b ec=%0d, want idx=3 iv=1 lk=0 oe=0 se=0 ec=0",
                     idx_out, idx_valid, locked, onehot_err, seq_err, err_count);
        else passed++;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ring_in = 4'b0000;
        rst2 = 1'b1; in_valid2 = 1'b0; ring_in2 = 4'b0000;
        test_reset();
        test_basic_lock();
        test_onehot_err();
        test_seq_err();
        test_gaps();
        test_err_saturate();
        test_reset_while_locked();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_sequence_checker.md
Name: ring_sequence_checker

Overview:
Receive-side companion to the team's one-hot ring counters. Each valid cycle it samples a WIDTH-bit ring word and decodes it to a binary index. It checks that the word is one-hot and that it follows the rotate-left sequence (bit i -> bit i+1, MSB wraps to bit 0). A lock FSM qualifies the stream and a saturating counter records errors. It sits at the far end of any ring/token bus, for self-check and debug observability.

Parameters:
WIDTH, 4, ring word width (>=2)
LOCK_COUNT, 2, consecutive correct transitions required to declare lock (>=1)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  ring_in is sampled this cycle
ring_in  input  WIDTH  ring word under test
idx_out  output  $clog2(WIDTH)  binary position of the set bit
idx_valid  output  1  idx_out updated from a valid one-hot sample
locked  output  1  stream is qualified
onehot_err  output  1  1-cycle pulse: sample not one-hot (zero or multi-bit)
seq_err  output  1  1-cycle pulse: one-hot sample, but not the expected successor
err_count  output  ERR_CNT_W  saturating count of error cycles

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- rst=1 at an edge: state=HUNT, idx_out=0, idx_valid=0, locked=0, onehot_err=0, seq_err=0, err_count=0, good_cnt=0, ref cleared. The sample at that edge is ignored.
- Latency: a sample taken at edge T is reflected on all outputs immediately after edge T.
- in_valid=0: state, ref, good_cnt and idx_out hold. idx_valid, onehot_err and seq_err go to 0. Gaps never cause errors.
- One-hot test: exactly one bit set. All-zero is illegal.
- Valid one-hot sample: idx_out = decoded index, idx_valid=1.
- Valid non-one-hot sample: idx_out holds, idx_valid=0.
- Expected successor = ref rotated left by 1, i.e. index (ref_idx+1) mod WIDTH. Index WIDTH-1 wraps to 0.
- FSM states: HUNT, VERIFY, LOCKED.
  - HUNT, one-hot: ref=sample, good_cnt=0, go to VERIFY. No flags.
  - HUNT, non-one-hot: onehot_err=1, stay in HUNT.
  - VERIFY, match: ref=sample, good_cnt+1. On reaching LOCK_COUNT, go to LOCKED and set locked=1.
  - VERIFY, one-hot mismatch: seq_err=1, ref=sample, good_cnt=0, stay in VERIFY.
  - VERIFY, non-one-hot: onehot_err=1, go to HUNT.
  - LOCKED, match: ref=sample, stay in LOCKED.
  - LOCKED, one-hot mismatch: seq_err=1, locked=0, ref=sample, good_cnt=0, go to VERIFY.
  - LOCKED, non-one-hot: onehot_err=1, locked=0, go to HUNT.
- onehot_err and seq_err are mutually exclusive.
- err_count increments by exactly 1 on any cycle where either flag asserts, and saturates at all-ones (no wrap).
- locked is 1 iff state==LOCKED.
- Repeated identical words (a stalled ring) are a mismatch and raise seq_err.

Decomposition:
- Package ring_pkg:
  - state enum (HUNT, VERIFY, LOCKED)
  - IDX_W = $clog2(WIDTH) helper
  - rotl1 function
- Sub-module ring_onehot_decode: combinational; ring_in -> {is_onehot, idx}. Reused by other ring consumers.
- Top holds the FSM, ref/good_cnt registers and the error counter.

Test Plan (WIDTH=4, LOCK_COUNT=2, ERR_CNT_W=8 unless stated):
1. Reset, then valid 0001,0010,0100,1000,0001 on consecutive cycles -> idx_out 0,1,2,3,0 with idx_valid=1 each. locked=1 after the 3rd sample edge. No flags; err_count=0.
2. Locked, after 0100, send 0011 -> onehot_err pulses 1 cycle, idx_valid=0, idx_out stays 2, locked=0, err_count=1. Next 1000 -> state VERIFY, no flag.
3. Locked, after 0010, send 1000 -> seq_err pulses, locked=0, err_count=1. Then 0001,0010 -> locked=1 after 0010. Then a repeated 0010 -> seq_err, err_count=2.
4. Sequence 0001,0010,0100,1000 with in_valid low for 3 cycles between each sample -> no flags, lock reached, flags/idx_valid low during gaps.
5. ERR_CNT_W=2: five consecutive 0000 samples -> onehot_err on each, err_count 1,2,3,3,3; locked stays 0.
6. Locked, then rst=1 for one edge with in_valid=1, ring_in=0100 -> next cycle all outputs at reset values, state HUNT. Then 1000 -> no seq_err (HUNT takes a new reference).
